axis_udp_packet_fifo: RTL and testbench
=======================================

# axis_udp_packet_fifo

Store-and-forward packet FIFO sitting directly downstream of `axis_udp_filter`, consuming its filtered UDP payload stream. It buffers each frame completely and releases it only after `tlast`, so the consumer never sees a partial frame. Frames that exceed `PAYLOAD_MAX_SIZE` or overflow the buffer are discarded whole and counted. Input is never back-pressured, so the filter never stalls.

## Interface
- `STREAM_DATA_WIDTH`, 32: data width in bits; a multiple of 8.
- `ADDR_WIDTH`, 9: log2 of buffer depth in words (512 words).
- `PAYLOAD_MAX_SIZE`, 1600: maximum accepted frame size in bytes. `MAX_WORDS = ceil(PAYLOAD_MAX_SIZE / (STREAM_DATA_WIDTH/8))`, which is 400 at the defaults.
- `axis_clk`  in  1  single clock for the whole block.
- `axis_a_rst_n`  in  1  reset; asynchronous assert, active-low, synchronous release upstream.
- `s_axis_tdata`  in  STREAM_DATA_WIDTH  payload from the filter.
- `s_axis_tvalid`  in  1  input word valid.
- `s_axis_tlast`  in  1  last word of the frame.
- `s_axis_tready`  out  1  0 in reset, 1 at all other times.
- `m_axis_tdata`  out  STREAM_DATA_WIDTH  buffered payload.
- `m_axis_tvalid`  out  1  output word valid.
- `m_axis_tlast`  out  1  last word of the frame.
- `m_axis_tready`  in  1  downstream ready.
- `frame_cnt_o`  out  16  committed frames; saturates at 0xFFFF.
- `drop_cnt_o`  out  16  dropped frames; saturates at 0xFFFF.
- `drop_o`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- **Storage:** memory of `2^ADDR_WIDTH` entries, each `{tlast, tdata}`.
- **Pointers:** `wr_ptr`, `wr_commit` and `rd_ptr`, each `ADDR_WIDTH+1` bits.
  - `used = wr_ptr - rd_ptr`, computed modulo `2^(ADDR_WIDTH+1)`.
  - Full when `used == 2^ADDR_WIDTH`.
  - All pointers wrap naturally.
- **Write FSM states:** `ST_IDLE`, `ST_FRAME`, `ST_DROP`. `wcnt` counts words of the current frame.
  - **ST_IDLE → ST_FRAME:** on a handshake without `tlast`; the word is written and `wcnt = 1`.
  - **Single-word frame:** a handshake with `tlast` in ST_IDLE is written and committed in that cycle; the FSM stays in ST_IDLE.
  - **ST_FRAME:** each handshake writes a word and increments `wcnt`.
  - **Commit:** on the `tlast` handshake, `wr_commit <= wr_ptr + 1`, `frame_cnt_o` increments, and the FSM returns to ST_IDLE.
- **Drop conditions**, checked on every input handshake in ST_IDLE or ST_FRAME:
  - the buffer is full, or
  - the word would be number `MAX_WORDS + 1`.
- **Drop actions**, taken when a condition is met:
  - the word is not written;
  - `wr_ptr <= wr_commit`;
  - `drop_o` pulses and `drop_cnt_o` increments;
  - the FSM enters ST_DROP, or stays in ST_IDLE if that word carried `tlast`.
- **ST_DROP:** discards handshakes until `tlast`, then returns to ST_IDLE. Nothing is written.
- **Simultaneous events:**
  - A word that is both the `MAX_WORDS+1`th and `tlast`: the frame is dropped.
  - A frame of exactly `MAX_WORDS` words: accepted.
  - Full and `tlast` on the same handshake: the frame is dropped.
- **Read side:** words are readable only while `rd_ptr != wr_commit`. `rd_ptr` advances on each output handshake.
- **Reset mid-operation:** all pointers, counters and FSM state clear immediately. Partial and buffered frames are lost.

## Timing
- **Reset values:** `s_axis_tready = 0`, `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `m_axis_tdata = 0`, counters = 0, `drop_o = 0`.
- **Write timing:** write and commit happen at the clock edge of the input handshake.
- **Latency:** with the buffer empty and a tlast handshake at edge N, `m_axis_tvalid` rises after edge N+1. Memory read is synchronous into the output register.
- **Throughput:** one word per cycle sustained while `m_axis_tready = 1`. A prefetch/skid output stage is required; no bubbles within or between committed frames.
- **AXIS hold rule:** `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` hold stable while `tvalid & !tready`.
- **Counter timing:** `drop_o` and both counters update at the edge of the triggering handshake.
- **Freeing space:** a word read at edge N frees its slot for a write at edge N+1.

## Structure
- Add `FIFO_CNT_WIDTH` (16) and the FSM state encodings to the shared `udp_filter.vh`.
- Compute `MAX_WORDS` as a localparam.
- Sub-module `axis_udp_fifo_ram`:
  - simple dual-port RAM, one write port and one synchronous read port;
  - width `STREAM_DATA_WIDTH+1`, depth `2^ADDR_WIDTH`;
  - infers block RAM.

## Test plan
- **Single frame:** 27-word frame (`0x00000001..0x0000001B`), `m_axis_tready = 1` → identical 27 words out, `tlast` on word 27, first `tvalid` 2 cycles after the input `tlast`, `frame_cnt_o = 1`.
- **Frame-size boundary:** 400-word frame → passed intact. Then a 401-word frame → nothing output, `drop_o` pulses once, `drop_cnt_o = 1`.
- **Overflow and recovery:** `m_axis_tready = 0`, send two 300-word frames → the first is kept and the second is dropped (full at word 213). Set `m_axis_tready = 1` → exactly 300 words out, then a new 10-word frame passes.
- **Back-pressure:** toggle `m_axis_tready` 1/0 each cycle over three back-to-back 5-word frames → 15 words in order, data stable while stalled, 3 `tlast` pulses.
- **Reset mid-frame:** pulse `axis_a_rst_n` low mid-frame after 10 words → all outputs 0 immediately. A following 8-word frame passes, `frame_cnt_o = 1`.
- **Back-to-back single words:** single-word frames (`tlast` on every word) for 600 cycles with `m_axis_tready = 1` → 600 words out, `frame_cnt_o = 600`.

Source files
------------

// File: rtl/axis_udp_packet_fifo_pkg.sv
// ============================================================================
// Module   : axis_udp_packet_fifo_pkg
// Brief    : Shared widths, write-FSM encoding and counter helper for the
//            UDP packet FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_udp_packet_fifo_pkg;

  localparam int FIFO_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DROP  = 2'd2
  } wr_state_t;

  // Statistics counters stick at all-ones rather than wrapping.
  function automatic logic [FIFO_CNT_WIDTH-1:0] sat_inc(input logic [FIFO_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_udp_fifo_ram.sv
// ============================================================================
// Module   : axis_udp_fifo_ram
// Brief    : Simple dual-port RAM, one write port and one registered read
//            port with enable, written to map onto block RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_udp_fifo_ram #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= r_mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/axis_udp_packet_fifo.sv
// ============================================================================
// Module   : axis_udp_packet_fifo
// Brief    : Store-and-forward AXIS packet FIFO; frames are released only once
//            complete, oversized or overflowing frames are dropped whole.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_udp_packet_fifo
  import axis_udp_packet_fifo_pkg::*;
#(
  parameter int STREAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH        = 9,
  parameter int PAYLOAD_MAX_SIZE  = 1600
) (
  input  logic                         axis_clk,
  input  logic                         axis_a_rst_n,
  input  logic [STREAM_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [STREAM_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic [FIFO_CNT_WIDTH-1:0]    frame_cnt_o,
  output logic [FIFO_CNT_WIDTH-1:0]    drop_cnt_o,
  output logic                         drop_o
);

  localparam int BYTES     = STREAM_DATA_WIDTH / 8;
  localparam int MAX_WORDS = (PAYLOAD_MAX_SIZE + BYTES - 1) / BYTES;
  localparam int WCNT_W    = $clog2(MAX_WORDS + 1);
  localparam int PTR_W     = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0]  DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [WCNT_W-1:0] MAX_WCNT  = WCNT_W'(MAX_WORDS);

  wr_state_t                  r_state, w_state_next;
  logic [WCNT_W-1:0]          r_wcnt, w_wcnt_next;
  logic [PTR_W-1:0]           r_wr_ptr, r_wr_commit, r_rd_ptr, r_fetch_ptr;
  logic                       r_in_ready, r_out_valid, r_drop;
  logic [FIFO_CNT_WIDTH-1:0]  r_frame_cnt, r_drop_cnt;
  logic                       w_we, w_commit, w_drop, w_load, w_full;
  logic                       w_in_hs, w_out_hs;
  logic [PTR_W-1:0]           w_used;
  logic [STREAM_DATA_WIDTH:0] w_rdata;

  assign w_in_hs  = s_axis_tvalid & r_in_ready;
  assign w_out_hs = r_out_valid & m_axis_tready;
  assign w_used   = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_used == DEPTH);
  // Fetch runs ahead of rd_ptr by the word parked in the output register,
  // so that word still counts as occupied until it is handed downstream.
  assign w_load   = (r_fetch_ptr != r_wr_commit) & (~r_out_valid | m_axis_tready);

  always_ff @(posedge axis_clk or negedge axis_a_rst_n) begin
    if (!axis_a_rst_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_wcnt_next  = r_wcnt;
    w_we         = 1'b0;
    w_commit     = 1'b0;
    w_drop       = 1'b0;
    if (w_in_hs) begin
      case (r_state)
        ST_IDLE, ST_FRAME: begin
          // r_wcnt is zero in ST_IDLE, so only an open frame can hit the size cap.
          if (w_full || (r_wcnt == MAX_WCNT)) begin
            w_drop       = 1'b1;
            w_wcnt_next  = '0;
            w_state_next = s_axis_tlast ? ST_IDLE : ST_DROP;
          end else begin
            w_we = 1'b1;
            if (s_axis_tlast) begin
              w_commit     = 1'b1;
              w_wcnt_next  = '0;
              w_state_next = ST_IDLE;
            end else begin
              w_wcnt_next  = r_wcnt + 1'b1;
              w_state_next = ST_FRAME;
            end
          end
        end
        ST_DROP: if (s_axis_tlast) w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge axis_clk or negedge axis_a_rst_n) begin
    if (!axis_a_rst_n) begin
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_rd_ptr    <= '0;
      r_fetch_ptr <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_in_ready <= 1'b1;
      r_drop     <= w_drop;
      if (w_drop)     r_wr_ptr <= r_wr_commit;
      else if (w_we)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_commit) begin
        r_wr_commit <= r_wr_ptr + 1'b1;
        r_frame_cnt <= sat_inc(r_frame_cnt);
      end
      if (w_drop)   r_drop_cnt  <= sat_inc(r_drop_cnt);
      if (w_load)   r_fetch_ptr <= r_fetch_ptr + 1'b1;
      if (w_out_hs) r_rd_ptr    <= r_rd_ptr + 1'b1;
      if (w_load)             r_out_valid <= 1'b1;
      else if (m_axis_tready) r_out_valid <= 1'b0;
    end
  end

  axis_udp_fifo_ram #(
    .WIDTH      (STREAM_DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (axis_clk),
    .wr_en   (w_we),
    .wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_en   (w_load),
    .rd_addr (r_fetch_ptr[ADDR_WIDTH-1:0]),
    .rd_data (w_rdata)
  );

  // The RAM read register has no reset; gate it so idle/reset outputs read zero.
  assign m_axis_tdata  = r_out_valid ? w_rdata[STREAM_DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = r_out_valid & w_rdata[STREAM_DATA_WIDTH];
  assign m_axis_tvalid = r_out_valid;
  assign s_axis_tready = r_in_ready;
  assign frame_cnt_o   = r_frame_cnt;
  assign drop_cnt_o    = r_drop_cnt;
  assign drop_o        = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_axis_udp_packet_fifo.sv
// ============================================================================
// Module   : tb_axis_udp_packet_fifo
// Brief    : Self-checking bench for axis_udp_packet_fifo with a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_udp_packet_fifo;

  localparam int DEPTH = 512;
  localparam int MAXW  = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b1;
  logic [15:0] frame_cnt, drop_cnt;
  logic        drop_o;

  always #5 clk = ~clk;

  axis_udp_packet_fifo dut (
    .axis_clk      (clk),
    .axis_a_rst_n  (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .frame_cnt_o   (frame_cnt),
    .drop_cnt_o    (drop_cnt),
    .drop_o        (drop_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: committed words awaiting output, plus the frame being collected.
  typedef struct {
    logic [31:0] data;
    logic        last;
    int          stamp;
  } word_t;

  word_t       exp_q[$];
  logic [31:0] pend_q[$];
  bit          m_drop_mode = 0, m_ready = 0, m_drop = 0, exp_valid;
  int          m_frames = 0, m_drops = 0, cyc = 0;
  int          out_words = 0, out_lasts = 0, drop_pulses = 0;
  word_t       w;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_q.delete();
      m_drop_mode = 0; m_ready = 0; m_drop = 0; m_frames = 0; m_drops = 0;
      check("rst_ctrl", {s_tready, m_tvalid, m_tlast, drop_o}, 4'b0000);
      check("rst_data", m_tdata, 0);
      check("rst_cnts", {frame_cnt, drop_cnt}, 0);
    end else begin
      // A word committed at edge N is visible after edge N+1.
      exp_valid = m_ready && exp_q.size() > 0 && exp_q[0].stamp < cyc - 1;
      check("s_tready", s_tready, m_ready);
      check("m_tvalid", m_tvalid, exp_valid);
      if (exp_valid) begin
        check("m_tdata", m_tdata, exp_q[0].data);
        check("m_tlast", m_tlast, exp_q[0].last);
      end
      check("frame_cnt", frame_cnt, m_frames);
      check("drop_cnt", drop_cnt, m_drops);
      check("drop_o", drop_o, m_drop);
      if (m_tvalid && m_tready) begin
        out_words++;
        if (m_tlast) out_lasts++;
      end
      if (drop_o) drop_pulses++;

      // Apply the upcoming edge: write side first, then the output handshake.
      m_drop = 0;
      if (m_ready && s_tvalid) begin
        if (m_drop_mode) begin
          if (s_tlast) m_drop_mode = 0;
        end else if (exp_q.size() + pend_q.size() >= DEPTH || pend_q.size() >= MAXW) begin
          pend_q.delete();
          m_drop = 1;
          if (m_drops < 65535) m_drops++;
          m_drop_mode = !s_tlast;
        end else begin
          pend_q.push_back(s_tdata);
          if (s_tlast) begin
            for (int i = 0; i < pend_q.size(); i++) begin
              w.data  = pend_q[i];
              w.last  = (i == pend_q.size() - 1);
              w.stamp = cyc;
              exp_q.push_back(w);
            end
            pend_q.delete();
            if (m_frames < 65535) m_frames++;
          end
        end
      end
      if (exp_valid && m_tready) void'(exp_q.pop_front());
      m_ready = 1;
    end
    cyc++;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      s_tdata  = base + i;
      s_tvalid = 1'b1;
      s_tlast  = (i == n - 1);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  int w0, l0, d0, lat;

  initial begin
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single 27-word frame
    w0 = out_words; l0 = out_lasts;
    send_frame(27, 32'h1);
    lat = 1;
    while (!m_tvalid && lat < 10) begin @(posedge clk); #1; lat++; end
    check("t1_latency", lat, 2);
    idle(40);
    check("t1_words", out_words - w0, 27);
    check("t1_lasts", out_lasts - l0, 1);
    check("t1_frame_cnt", frame_cnt, 1);

    // Size boundary: 400 accepted, 401 dropped
    w0 = out_words; d0 = drop_pulses;
    send_frame(400, 32'h1000);
    idle(5);
    send_frame(401, 32'h2000);
    idle(50);
    check("t2_words", out_words - w0, 400);
    check("t2_drop_pulses", drop_pulses - d0, 1);
    check("t2_drop_cnt", drop_cnt, 1);
    check("t2_frame_cnt", frame_cnt, 2);

    // Overflow with output stalled, then recovery
    m_tready = 1'b0;
    w0 = out_words;
    idle(2);
    send_frame(300, 32'h10000);
    send_frame(300, 32'h20000);
    idle(5);
    check("t3_stalled_words", out_words - w0, 0);
    check("t3_drop_cnt", drop_cnt, 2);
    check("t3_frame_cnt", frame_cnt, 3);
    m_tready = 1'b1;
    idle(320);
    check("t3_drained_words", out_words - w0, 300);
    w0 = out_words;
    send_frame(10, 32'h30000);
    idle(20);
    check("t3_recovery_words", out_words - w0, 10);
    check("t3_recovery_frames", frame_cnt, 4);

    // Toggling back-pressure across three back-to-back frames
    w0 = out_words; l0 = out_lasts;
    fork
      begin
        send_frame(5, 32'h40000);
        send_frame(5, 32'h40010);
        send_frame(5, 32'h40020);
      end
      begin
        repeat (30) begin @(posedge clk); #1; m_tready = ~m_tready; end
      end
    join
    m_tready = 1'b1;
    idle(20);
    check("t4_words", out_words - w0, 15);
    check("t4_lasts", out_lasts - l0, 3);
    check("t4_frame_cnt", frame_cnt, 7);

    // Reset mid-frame with a committed frame still buffered
    m_tready = 1'b0;
    send_frame(3, 32'h50000);
    for (int i = 0; i < 10; i++) begin
      s_tdata = 32'h55000 + i; s_tvalid = 1'b1; s_tlast = 1'b0;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    check("t5_pre_valid", m_tvalid, 1);
    w0 = out_words;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", m_tvalid, 0);
    check("t5_rst_data", m_tdata, 0);
    check("t5_rst_ready", s_tready, 0);
    check("t5_rst_frame_cnt", frame_cnt, 0);
    idle(1);
    rst_n = 1'b1;
    idle(2);
    m_tready = 1'b1;
    send_frame(8, 32'h60000);
    idle(20);
    check("t5_words", out_words - w0, 8);
    check("t5_frame_cnt", frame_cnt, 1);

    // 600 back-to-back single-word frames
    pulse_reset();
    w0 = out_words; l0 = out_lasts;
    for (int i = 0; i < 600; i++) begin
      s_tdata = 32'h70000 + i; s_tvalid = 1'b1; s_tlast = 1'b1;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    idle(10);
    check("t6_words", out_words - w0, 600);
    check("t6_lasts", out_lasts - l0, 600);
    check("t6_frame_cnt", frame_cnt, 600);
    check("t6_drop_cnt", drop_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
